burst_line_adapter: RTL and testbench

Memory-side responder for the cache arbiter's line interface. Accepts one 256-bit cacheline read or write request at a time from the arbiter and converts it into a 4-beat, 64-bit burst transaction on the banked memory (bmem) port. Reads are reassembled into a full line; writes are serialized into beats. Line completion is reported with a single-cycle response pulse.

---
 rtl/burst_line_adapter.sv | 145 ++++++++++++++
 tb/tb_burst_line_adapter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/burst_line_adapter.sv
// rtl/burst_line_adapter.sv - cacheline request to 4-beat 64-bit bmem burst adapter
module burst_line_adapter #(
   parameter int LINE_BYTES = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [31:0]  line_addr,
   input  logic         line_read,
   input  logic         line_write,
   input  logic [255:0] line_wdata,
   output logic [255:0] line_rdata,
   output logic         line_resp,
   output logic [31:0]  bmem_addr,
   output logic         bmem_read,
   output logic         bmem_write,
   output logic [63:0]  bmem_wdata,
   input  logic         bmem_ready,
   input  logic [31:0]  bmem_raddr,
   input  logic [63:0]  bmem_rdata,
   input  logic         bmem_rvalid
);

   // counter value of the final beat in a line (LINE_BYTES=32 -> 3)
   localparam logic [1:0] LAST_BEAT = 2'(LINE_BYTES / 8 - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_CMD   = 3'd1,
      RD_WAIT  = 3'd2,
      WR_BURST = 3'd3,
      DONE     = 3'd4,
      GUARD    = 3'd5
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    cnt_q, cnt_d;
   logic [255:0]  wbuf_q, wbuf_d;
   logic [255:0]  line_rdata_q, line_rdata_d;
   logic          line_resp_q, line_resp_d;
   logic [31:0]   bmem_addr_q, bmem_addr_d;
   logic          bmem_read_q, bmem_read_d;
   logic          bmem_write_q, bmem_write_d;
   logic [63:0]   bmem_wdata_q, bmem_wdata_d;

   logic [1:0]    cnt_inc;
   logic          beat_hit;

   assign cnt_inc  = cnt_q + 2'd1;
   // only beats tagged with the pending line address belong to this burst
   assign beat_hit = bmem_rvalid && (bmem_raddr == bmem_addr_q);

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // next-state logic; a write wins over a simultaneous read (writeback before fill)
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (line_write)     state_d = WR_BURST;
            else if (line_read) state_d = RD_CMD;
         end
         RD_CMD:   if (bmem_ready) state_d = RD_WAIT;
         RD_WAIT:  if (beat_hit && cnt_q == LAST_BEAT) state_d = DONE;
         WR_BURST: if (bmem_ready && cnt_q == LAST_BEAT) state_d = DONE;
         DONE:     state_d = GUARD;
         GUARD:    state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // next values of the registered outputs and datapath; strobes follow the next state
   always_comb begin
      cnt_d        = cnt_q;
      wbuf_d       = wbuf_q;
      line_rdata_d = line_rdata_q;
      bmem_addr_d  = bmem_addr_q;
      bmem_wdata_d = bmem_wdata_q;
      line_resp_d  = (state_d == DONE);
      bmem_read_d  = (state_d == RD_CMD);
      bmem_write_d = (state_d == WR_BURST);
      case (state_q)
         IDLE: begin
            if (line_write || line_read) begin
               bmem_addr_d = line_addr & ~32'h0000_001F;
               cnt_d       = 2'd0;
            end
            if (line_write) begin
               wbuf_d       = line_wdata;
               bmem_wdata_d = line_wdata[63:0];
            end
         end
         RD_CMD: begin
            if (bmem_ready) cnt_d = 2'd0;
         end
         RD_WAIT: begin
            if (beat_hit) begin
               line_rdata_d[{cnt_q, 6'd0} +: 64] = bmem_rdata;
               cnt_d = cnt_inc;
            end
         end
         WR_BURST: begin
            if (bmem_ready) begin
               cnt_d = cnt_inc;
               if (cnt_q != LAST_BEAT) bmem_wdata_d = wbuf_q[{cnt_inc, 6'd0} +: 64];
            end
         end
         default: ;
      endcase
   end

   // datapath and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q        <= 2'd0;
         wbuf_q       <= '0;
         line_rdata_q <= '0;
         line_resp_q  <= 1'b0;
         bmem_addr_q  <= '0;
         bmem_read_q  <= 1'b0;
         bmem_write_q <= 1'b0;
         bmem_wdata_q <= '0;
      end else begin
         cnt_q        <= cnt_d;
         wbuf_q       <= wbuf_d;
         line_rdata_q <= line_rdata_d;
         line_resp_q  <= line_resp_d;
         bmem_addr_q  <= bmem_addr_d;
         bmem_read_q  <= bmem_read_d;
         bmem_write_q <= bmem_write_d;
         bmem_wdata_q <= bmem_wdata_d;
      end
   end

   assign line_rdata = line_rdata_q;
   assign line_resp  = line_resp_q;
   assign bmem_addr  = bmem_addr_q;
   assign bmem_read  = bmem_read_q;
   assign bmem_write = bmem_write_q;
   assign bmem_wdata = bmem_wdata_q;

endmodule

// File: tb/tb_burst_line_adapter.sv
// tb/tb_burst_line_adapter.sv - directed self-checking bench for burst_line_adapter
module tb_burst_line_adapter;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  line_addr;
   logic         line_read;
   logic         line_write;
   logic [255:0] line_wdata;
   logic [255:0] line_rdata;
   logic         line_resp;
   logic [31:0]  bmem_addr;
   logic         bmem_read;
   logic         bmem_write;
   logic [63:0]  bmem_wdata;
   logic         bmem_ready;
   logic [31:0]  bmem_raddr;
   logic [63:0]  bmem_rdata;
   logic         bmem_rvalid;

   int n_vec = 0;
   int n_err = 0;

   burst_line_adapter #(.LINE_BYTES(32)) dut (
      .clk(clk), .rst(rst),
      .line_addr(line_addr), .line_read(line_read), .line_write(line_write),
      .line_wdata(line_wdata), .line_rdata(line_rdata), .line_resp(line_resp),
      .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
      .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
      .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // read one line; beats stream from cycle 2, optional stale beat before beat index stale_at
   task automatic read_txn(input string tag, input logic [31:0] a, input logic [255:0] line,
                           input int stale_at, input int exp_resp);
      int k = 0;
      int rd_cycles = 0;
      int resp_cycle = -1;
      bit stale_sent = 0;
      @(negedge clk);
      line_addr = a; line_read = 1'b1; bmem_ready = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (bmem_read) begin
            rd_cycles++;
            chk({tag, "_addr"}, bmem_addr, {a[31:5], 5'b0});
         end
         if (line_resp) begin
            resp_cycle = i;
            break;
         end
         if (i >= 2 && k < 4) begin
            bmem_rvalid = 1'b1;
            if (k == stale_at && !stale_sent) begin
               bmem_raddr = 32'h0000_2000;
               bmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
               stale_sent = 1;
            end else begin
               bmem_raddr = {a[31:5], 5'b0};
               bmem_rdata = line[k*64 +: 64];
               k++;
            end
         end else begin
            bmem_rvalid = 1'b0;
         end
      end
      bmem_rvalid = 1'b0;
      line_read = 1'b0;
      chk({tag, "_resp_cycle"}, resp_cycle, exp_resp);
      chk({tag, "_read_cycles"}, rd_cycles, 1);
      chk({tag, "_rdata"}, line_rdata, line);
      @(negedge clk);
      chk({tag, "_resp_pulse"}, line_resp, 1'b0);
      repeat (2) @(negedge clk);
   endtask

   // write one line; stall = number of ready-low cycles while beat 1 is presented
   task automatic write_txn(input string tag, input logic [31:0] a, input logic [255:0] d,
                            input int stall, input bit with_read, input int exp_resp);
      logic [63:0] acc [4];
      int nacc = 0;
      int d1_cycles = 0;
      int resp_cycle = -1;
      int stall_left = stall;
      bit rd_seen = 0;
      @(negedge clk);
      line_addr = a; line_wdata = d; line_write = 1'b1; line_read = with_read; bmem_ready = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (i == 1) line_wdata = ~d;
         if (bmem_read) rd_seen = 1;
         if (line_resp) begin
            resp_cycle = i;
            break;
         end
         if (bmem_write) begin
            if (nacc == 0) chk({tag, "_addr"}, bmem_addr, {a[31:5], 5'b0});
            if (bmem_wdata == d[127:64]) d1_cycles++;
            if (nacc == 1 && stall_left > 0) begin
               bmem_ready = 1'b0;
               stall_left--;
            end else begin
               bmem_ready = 1'b1;
               if (nacc < 4) acc[nacc] = bmem_wdata;
               nacc++;
            end
         end
      end
      line_write = 1'b0;
      bmem_ready = 1'b1;
      chk({tag, "_resp_cycle"}, resp_cycle, exp_resp);
      chk({tag, "_beats"}, nacc, 4);
      for (int b = 0; b < 4; b++) chk($sformatf("%s_beat%0d", tag, b), acc[b], d[b*64 +: 64]);
      chk({tag, "_d1_cycles"}, d1_cycles, 1 + stall);
      chk({tag, "_no_read"}, rd_seen, 1'b0);
      // GUARD cycle: requester may still be holding line_read
      @(negedge clk);
      chk({tag, "_resp_pulse"}, line_resp, 1'b0);
      line_read = 1'b0;
      @(negedge clk);
      chk({tag, "_guard_read"}, bmem_read, 1'b0);
      @(negedge clk);
      chk({tag, "_idle_read"}, bmem_read, 1'b0);
      chk({tag, "_idle_write"}, bmem_write, 1'b0);
   endtask

   localparam logic [255:0] RD_LINE = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                       64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
   localparam logic [255:0] RD_LINE2 = {64'hA5A5_0000_1111_0003, 64'hA5A5_0000_1111_0002,
                                        64'hA5A5_0000_1111_0001, 64'hA5A5_0000_1111_0000};
   localparam logic [255:0] WR_LINE = {64'hD3D3_0303_D3D3_0303, 64'hD2D2_0202_D2D2_0202,
                                       64'hD1D1_0101_D1D1_0101, 64'hD0D0_0000_D0D0_0000};

   initial begin
      rst = 1'b1;
      line_addr = '0; line_read = 1'b0; line_write = 1'b0; line_wdata = '0;
      bmem_ready = 1'b0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_resp", line_resp, 1'b0);
      chk("rst_read", bmem_read, 1'b0);
      chk("rst_write", bmem_write, 1'b0);
      chk("rst_addr", bmem_addr, 32'h0);
      chk("rst_rdata", line_rdata, 256'h0);

      read_txn("rd", 32'h0000_1234, RD_LINE, -1, 6);
      write_txn("wr", 32'h0000_0040, WR_LINE, 0, 1'b0, 5);
      write_txn("wr_stall", 32'h0000_0040, WR_LINE, 3, 1'b0, 8);
      read_txn("rd_stale", 32'h0000_1234, RD_LINE2, 2, 7);
      write_txn("wr_both", 32'h0000_0060, WR_LINE, 0, 1'b1, 5);

      // asynchronous reset in the middle of a write burst
      @(negedge clk);
      line_addr = 32'h0000_0080; line_wdata = WR_LINE; line_write = 1'b1; bmem_ready = 1'b0;
      @(negedge clk);
      chk("mid_write_pre", bmem_write, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_write", bmem_write, 1'b0);
      chk("mid_rst_wdata", bmem_wdata, 64'h0);
      chk("mid_rst_addr", bmem_addr, 32'h0);
      chk("mid_rst_resp", line_resp, 1'b0);
      @(negedge clk);
      line_write = 1'b0;
      rst = 1'b0;
      bmem_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_resp", line_resp, 1'b0);
         chk("post_rst_write", bmem_write, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
